fifo_ctrl: RTL and testbench

Pointer and flag controller that turns the register file into a synchronous FIFO. It sits directly upstream of the register file and drives its write enable, write address and read address. Producer and consumer handshakes terminate here. Depth is 2**ADDR_WIDTH entries. Read data comes combinationally from the register file at the head entry, so it is valid whenever empty is low.

---
 rtl/fifo_ctrl.sv | 69 ++++++
 tb/tb_fifo_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller that turns a combinational-read register file
// into a synchronous FIFO of depth 2**ADDR_WIDTH.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  do_wr;
  logic                  do_rd;
  logic [ADDR_WIDTH:0]   count_next;

  // A push into a full FIFO is still taken when the head is popped in the same cycle.
  always_comb begin
    do_wr = wr && (!full || rd);
    do_rd = rd && !empty;
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign wr_en       = do_wr;
  assign w_addr      = w_ptr;
  assign r_addr      = r_ptr;
  assign almost_full = (count >= AF_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + 1'b1;
      if (do_rd) r_ptr <= r_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
      // Sticky error flags; a pop on empty is not an error when a write lands alongside it.
      if (wr && !do_wr)           overflow  <= 1'b1;
      if (rd && !do_rd && !do_wr) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_ctrl;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          wr_en, full, empty, almost_full, overflow, underflow;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;
  logic [7:0]    rf [DEPTH];
  logic [7:0]    head;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  int  m_wp = 0;
  int  m_rp = 0;
  bit  m_ovf = 1'b0;
  bit  m_udf = 1'b0;

  fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign head = rf[r_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file write and reference model update.
  initial forever begin
    int  sz;
    bit  aw, ar;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (wr_en) rf[w_addr] = din;
      sz = q.size();
      aw = wr && (sz < DEPTH || rd);
      ar = rd && (sz > 0);
      if (wr && !aw) m_ovf = 1'b1;
      if (rd && !ar && !aw) m_udf = 1'b1;
      if (ar) begin
        void'(q.pop_front());
        m_rp = (m_rp + 1) % DEPTH;
      end
      if (aw) begin
        q.push_back(din);
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("m_count", count, q.size());
    chk("m_full", full, q.size() == DEPTH);
    chk("m_empty", empty, q.size() == 0);
    chk("m_almost_full", almost_full, q.size() >= AF);
    chk("m_w_addr", w_addr, m_wp);
    chk("m_r_addr", r_addr, m_rp);
    chk("m_overflow", overflow, m_ovf);
    chk("m_underflow", underflow, m_udf);
    chk("m_wr_en", wr_en, wr && (q.size() < DEPTH || rd));
    if (q.size() > 0) chk("m_head", head, q[0]);
  end

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; din = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  logic [7:0] exp_seq [6];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ptrs", {w_addr, r_addr}, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill A1..A4
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'hA1 + 8'(i));
      chk("fill_wr_en", wr_en, 1);
      chk("fill_w_addr", w_addr, i);
      step();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 3);
    end
    chk("fill_full", full, 1);
    chk("fill_wrap", w_addr, 0);

    // Overflow with 0xFF
    drive(1, 0, 8'hFF);
    chk("ovf_wr_en", wr_en, 0);
    step();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", head, 8'hA1);

    // Drain, then one extra pop
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'h00);
      chk("drain_r_addr", r_addr, i);
      chk("drain_head", head, 8'hA1 + 8'(i));
      step();
    end
    chk("drain_empty", empty, 1);
    drive(0, 1, 8'h00);
    step();
    chk("udf_flag", underflow, 1);
    chk("udf_r_addr", r_addr, 0);

    // Refill C0..C3, then 6 cycles of simultaneous push/pop while full
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'hC0 + 8'(i));
      step();
    end
    exp_seq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hE0, 8'hE1};
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 8'hE0 + 8'(i));
      chk("rw_wr_en", wr_en, 1);
      chk("rw_head", head, exp_seq[i]);
      step();
      chk("rw_full", full, 1);
    end
    chk("rw_count", count, 4);
    chk("rw_r_addr", r_addr, 2);
    chk("rw_w_addr", w_addr, 2);
    chk("rw_head_after", head, 8'hE2);

    // Fresh reset, then push+pop on empty
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 1, 8'hF0);
    chk("ew_wr_en", wr_en, 1);
    step();
    chk("ew_count", count, 1);
    chk("ew_empty", empty, 0);
    chk("ew_underflow", underflow, 0);
    chk("ew_head", head, 8'hF0);

    // Async reset mid-cycle at count 3
    drive(1, 0, 8'hF1); step();
    drive(1, 0, 8'hF2); step();
    chk("mid_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_af", almost_full, 0);
    chk("mid_ptrs", {w_addr, r_addr}, 0);
    chk("mid_flags", {overflow, underflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 8'hD0);
    chk("post_w_addr", w_addr, 0);
    chk("post_wr_en", wr_en, 1);
    step();
    chk("post_count", count, 1);
    chk("post_head", head, 8'hD0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
